bellek_hakemi: RTL and testbench

//  Two-master arbiter/sequencer for the processor's single memory port.
//  - Shares the one anabellek port between the instruction-fetch requester (getir_*) and the load/store requester (veri_*).
//  - Sequences each access through a fixed idle/access/response FSM and returns read data with a one-cycle ready pulse.
//  - Sits between the processor core's stage logic and anabellek.

---
 rtl/bellek_hakemi.sv | 124 ++++++++++++
 tb/tb_bellek_hakemi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_hakemi.sv
// rtl/bellek_hakemi.sv - two-master arbiter/sequencer for the single anabellek port
// Optional build macro HAKEM_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed veri priority.
module bellek_hakemi #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT = 32,
  parameter int BELLEK_GECIKME = 1,
  parameter logic [ADRES_BIT-1:0] SIFIR_ADRES = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 getir_istek,
  input  logic [ADRES_BIT-1:0] getir_adres,
  output logic [VERI_BIT-1:0]  getir_veri,
  output logic                 getir_hazir,
  input  logic                 veri_istek,
  input  logic [ADRES_BIT-1:0] veri_adres,
  input  logic                 veri_yaz,
  input  logic [VERI_BIT-1:0]  veri_yaz_veri,
  output logic [VERI_BIT-1:0]  veri_oku_veri,
  output logic                 veri_hazir,
  output logic [ADRES_BIT-1:0] bellek_adres,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz,
  output logic                 mesgul
);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    ERISIM = 2'd1,
    YANIT  = 2'd2
  } durum_t;

  localparam logic GETIR = 1'b0;
  localparam logic VERI  = 1'b1;
  localparam logic [3:0] SAYAC_YUK = 4'(BELLEK_GECIKME - 1);

  durum_t               durum, durum_n;
  logic [3:0]           sayac;
  logic                 ilk;
  logic                 kazanan, kazanan_n;
  logic [ADRES_BIT-1:0] adres_r;
  logic                 yaz_r;
  logic [VERI_BIT-1:0]  yveri_r;
`ifdef HAKEM_ROUND_ROBIN_EN
  logic                 son;
`endif

  always_comb begin
    durum_n   = durum;
    kazanan_n = GETIR;
`ifdef HAKEM_ROUND_ROBIN_EN
    // on a tie the port that did not win last time gets the grant
    if (getir_istek && veri_istek)
      kazanan_n = (son == VERI) ? GETIR : VERI;
    else
      kazanan_n = veri_istek ? VERI : GETIR;
`else
    kazanan_n = veri_istek ? VERI : GETIR;
`endif
    case (durum)
      BOSTA:   if (getir_istek || veri_istek) durum_n = ERISIM;
      ERISIM:  if (!ilk && sayac == '0) durum_n = YANIT;
      YANIT:   durum_n = BOSTA;
      default: durum_n = BOSTA;
    endcase

    getir_hazir     = (durum == YANIT) && (kazanan == GETIR);
    veri_hazir      = (durum == YANIT) && (kazanan == VERI);
    mesgul          = (durum != BOSTA);
    bellek_adres    = adres_r;
    bellek_yaz      = (durum == ERISIM) && ilk && yaz_r;
    bellek_yaz_veri = bellek_yaz ? yveri_r : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      durum         <= BOSTA;
      sayac         <= '0;
      ilk           <= 1'b0;
      kazanan       <= VERI;
      adres_r       <= SIFIR_ADRES;
      yaz_r         <= 1'b0;
      yveri_r       <= '0;
      getir_veri    <= '0;
      veri_oku_veri <= '0;
`ifdef HAKEM_ROUND_ROBIN_EN
      son           <= VERI;
`endif
    end else begin
      durum <= durum_n;
      case (durum)
        BOSTA: begin
          if (getir_istek || veri_istek) begin
            kazanan <= kazanan_n;
            adres_r <= (kazanan_n == VERI) ? veri_adres : getir_adres;
            yaz_r   <= (kazanan_n == VERI) && veri_yaz;
            yveri_r <= ((kazanan_n == VERI) && veri_yaz) ? veri_yaz_veri : '0;
            sayac   <= SAYAC_YUK;
            ilk     <= 1'b1;
`ifdef HAKEM_ROUND_ROBIN_EN
            son     <= kazanan_n;
`endif
          end
        end
        ERISIM: begin
          // first cycle presents address/strobe; the latency count runs after it
          if (ilk) begin
            ilk <= 1'b0;
          end else if (sayac == '0) begin
            if (!yaz_r) begin
              if (kazanan == VERI) veri_oku_veri <= bellek_oku_veri;
              else                 getir_veri    <= bellek_oku_veri;
            end
          end else begin
            sayac <= sayac - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// tb/tb_bellek_hakemi.sv - self-checking bench for bellek_hakemi (latency 1 and 3 instances)
module tb_bellek_hakemi;
  localparam logic [31:0] SIFIR = 32'h8000_0000;
  localparam logic [31:0] A4 = 32'h8000_0004;
  localparam logic [31:0] AC = 32'h8000_0100;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] IN = 32'h00A0_0093;
  localparam int G1 = 1;
`ifdef HAKEM_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic gi, vi, vw, gh, vh, by, busy;
  logic [31:0] ga, gv, va, vwd, vrd, ba, brd, bwd;
  logic gi3, vi3, vw3, gh3, vh3, by3, busy3;
  logic [31:0] ga3, gv3, va3, vwd3, vrd3, ba3, brd3, bwd3;

  logic [31:0] mem [128];
  logic [31:0] shadow [128];
  assign brd  = mem[ba[8:2]];
  assign brd3 = mem[ba3[8:2]];

  int n_chk = 0;
  int n_fail = 0;

  bellek_hakemi #(.BELLEK_GECIKME(1)) dut (
    .clk(clk), .rst(rst),
    .getir_istek(gi), .getir_adres(ga), .getir_veri(gv), .getir_hazir(gh),
    .veri_istek(vi), .veri_adres(va), .veri_yaz(vw), .veri_yaz_veri(vwd),
    .veri_oku_veri(vrd), .veri_hazir(vh),
    .bellek_adres(ba), .bellek_oku_veri(brd), .bellek_yaz_veri(bwd),
    .bellek_yaz(by), .mesgul(busy)
  );

  bellek_hakemi #(.BELLEK_GECIKME(3)) dut3 (
    .clk(clk), .rst(rst),
    .getir_istek(gi3), .getir_adres(ga3), .getir_veri(gv3), .getir_hazir(gh3),
    .veri_istek(vi3), .veri_adres(va3), .veri_yaz(vw3), .veri_yaz_veri(vwd3),
    .veri_oku_veri(vrd3), .veri_hazir(vh3),
    .bellek_adres(ba3), .bellek_oku_veri(brd3), .bellek_yaz_veri(bwd3),
    .bellek_yaz(by3), .mesgul(busy3)
  );

  typedef struct {
    logic gi; logic [31:0] ga;
    logic vi; logic [31:0] va; logic vw; logic [31:0] vwd;
    logic e_gh; logic e_vh; logic e_by; logic e_busy;
    logic [31:0] e_ba; logic [31:0] e_bwd; logic [31:0] e_gv; logic [31:0] e_vrd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // one clock edge; the memory stub commits a strobed write at the edge
  task automatic step();
    logic w;
    logic [6:0] wa;
    logic [31:0] wd;
    w = by; wa = ba[8:2]; wd = bwd;
    @(posedge clk);
    if (w) mem[wa] = wd;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gi = 0; ga = 0; vi = 0; va = 0; vw = 0; vwd = 0;
    gi3 = 0; ga3 = 0; vi3 = 0; va3 = 0; vw3 = 0; vwd3 = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // transaction-level reference: grant, G+1 access cycles, one response cycle
  int m_rem;
  bit m_yanit, m_first, m_kaz, m_son, m_wr;
  logic [31:0] m_adres, m_wd, m_gv, m_vrd;

  task automatic model_reset();
    m_rem = 0; m_yanit = 0; m_first = 0; m_kaz = 1; m_son = 1; m_wr = 0;
    m_adres = SIFIR; m_wd = 0; m_gv = 0; m_vrd = 0;
    for (int i = 0; i < 128; i++) shadow[i] = mem[i];
  endtask

  task automatic model_edge();
    if (m_yanit) begin
      m_yanit = 0;
    end else if (m_rem > 0) begin
      m_first = 0;
      m_rem--;
      if (m_rem == 0) begin
        m_yanit = 1;
        if (!m_wr) begin
          if (m_kaz) m_vrd = shadow[m_adres[8:2]];
          else       m_gv  = shadow[m_adres[8:2]];
        end
      end
    end else if (gi || vi) begin
      if (gi && vi) m_kaz = RR ? !m_son : 1'b1;
      else          m_kaz = vi;
      m_son = m_kaz;
      m_adres = m_kaz ? va : ga;
      m_wr = m_kaz && vw;
      m_wd = m_wr ? vwd : 32'h0;
      if (m_wr) shadow[m_adres[8:2]] = vwd;
      m_first = 1;
      m_rem = G1 + 1;
    end
  endtask

  task automatic model_check();
    chk("rnd_getir_hazir", 32'(gh), 32'(m_yanit && !m_kaz));
    chk("rnd_veri_hazir", 32'(vh), 32'(m_yanit && m_kaz));
    chk("rnd_bellek_yaz", 32'(by), 32'(m_first && m_wr));
    chk("rnd_bellek_yaz_veri", bwd, (m_first && m_wr) ? m_wd : 32'h0);
    chk("rnd_mesgul", 32'(busy), 32'(m_rem > 0 || m_yanit));
    chk("rnd_bellek_adres", ba, m_adres);
    chk("rnd_getir_veri", gv, m_gv);
    chk("rnd_veri_oku_veri", vrd, m_vrd);
  endtask

  initial begin
    int ng, first_h, mc;
    logic [3:0] win, exp_win;

    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[1] = IN;
    mem[64] = 32'h0;

    tbl[0]  = '{1, A4, 0, 0, 0, 0,   0, 0, 0, 1, A4, 0, 0, 0};
    tbl[1]  = '{1, A4, 0, 0, 0, 0,   0, 0, 0, 1, A4, 0, 0, 0};
    tbl[2]  = '{1, A4, 0, 0, 0, 0,   1, 0, 0, 1, A4, 0, IN, 0};
    tbl[3]  = '{0, A4, 0, 0, 0, 0,   0, 0, 0, 0, A4, 0, IN, 0};
    tbl[4]  = '{0, 0, 1, AC, 1, DB,  0, 0, 1, 1, AC, DB, IN, 0};
    tbl[5]  = '{0, 0, 1, AC, 1, DB,  0, 0, 0, 1, AC, 0, IN, 0};
    tbl[6]  = '{0, 0, 1, AC, 1, DB,  0, 1, 0, 1, AC, 0, IN, 0};
    tbl[7]  = '{0, 0, 0, AC, 0, 0,   0, 0, 0, 0, AC, 0, IN, 0};
    tbl[8]  = '{0, 0, 1, AC, 0, 0,   0, 0, 0, 1, AC, 0, IN, 0};
    tbl[9]  = '{0, 0, 1, AC, 0, 0,   0, 0, 0, 1, AC, 0, IN, 0};
    tbl[10] = '{0, 0, 1, AC, 0, 0,   0, 1, 0, 1, AC, 0, IN, DB};
    tbl[11] = '{0, 0, 0, AC, 0, 0,   0, 0, 0, 0, AC, 0, IN, DB};

    // reset state
    do_reset();
    chk("rst_bellek_adres", ba, SIFIR);
    chk("rst_bellek_yaz", 32'(by), 0);
    chk("rst_getir_hazir", 32'(gh), 0);
    chk("rst_veri_hazir", 32'(vh), 0);
    chk("rst_mesgul", 32'(busy), 0);
    chk("rst_getir_veri", gv, 0);
    chk("rst_veri_oku_veri", vrd, 0);
    chk("rst_bellek_yaz_veri", bwd, 0);
    chk("rst3_bellek_adres", ba3, SIFIR);

    // fetch, store, load vectors
    for (int i = 0; i < 12; i++) begin
      gi = tbl[i].gi; ga = tbl[i].ga;
      vi = tbl[i].vi; va = tbl[i].va; vw = tbl[i].vw; vwd = tbl[i].vwd;
      step();
      chk($sformatf("t%0d_getir_hazir", i), 32'(gh), 32'(tbl[i].e_gh));
      chk($sformatf("t%0d_veri_hazir", i), 32'(vh), 32'(tbl[i].e_vh));
      chk($sformatf("t%0d_bellek_yaz", i), 32'(by), 32'(tbl[i].e_by));
      chk($sformatf("t%0d_mesgul", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("t%0d_bellek_adres", i), ba, tbl[i].e_ba);
      chk($sformatf("t%0d_bellek_yaz_veri", i), bwd, tbl[i].e_bwd);
      chk($sformatf("t%0d_getir_veri", i), gv, tbl[i].e_gv);
      chk($sformatf("t%0d_veri_oku_veri", i), vrd, tbl[i].e_vrd);
    end

    // contention: both requesters held for four grants
    do_reset();
    gi = 1; ga = A4; vi = 1; va = SIFIR | 32'h8; vw = 0;
    ng = 0; win = 4'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      chk("cont_one_hazir", 32'(gh && vh), 0);
      if (gh || vh) begin
        win[ng] = vh;
        ng++;
      end
    end
    gi = 0; vi = 0;
    exp_win = RR ? 4'b1010 : 4'b1111;
    chk("cont_grants", 32'(ng), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), 32'(win[i]), 32'(exp_win[i]));
    step();

    // reset during the first access cycle of a store
    do_reset();
    vi = 1; vw = 1; va = SIFIR | 32'h108; vwd = 32'h1234_5678;
    step();
    chk("rstmid_yaz_first", 32'(by), 1);
    chk("rstmid_yaz_veri_first", bwd, 32'h1234_5678);
    rst = 1; vi = 0; vw = 0;
    step();
    rst = 0;
    chk("rstmid_yaz_after", 32'(by), 0);
    chk("rstmid_mesgul", 32'(busy), 0);
    chk("rstmid_veri_hazir", 32'(vh), 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rstmid_no_hazir", 32'(vh), 0);
      chk("rstmid_idle", 32'(busy), 0);
    end

    // latency 3 fetch on the second instance
    do_reset();
    gi3 = 1; ga3 = A4;
    first_h = -1; mc = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (busy3) mc++;
      if (gh3 && first_h < 0) begin
        first_h = e;
        chk("lat3_data", gv3, IN);
        gi3 = 0;
      end
    end
    chk("lat3_edges", 32'(first_h), 4);
    chk("lat3_mesgul_cycles", 32'(mc), 5);

    // randomized traffic against the transaction model
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      model_edge();
      step();
      model_check();
      if (!gi || (m_yanit && !m_kaz)) begin
        gi = ($urandom_range(0, 2) != 0);
        ga = SIFIR | (32'($urandom_range(0, 127)) << 2);
      end
      if (!vi || (m_yanit && m_kaz)) begin
        vi = ($urandom_range(0, 2) != 0);
        va = SIFIR | (32'($urandom_range(0, 127)) << 2);
        vw = 1'($urandom_range(0, 1));
        vwd = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
